// File: rtl/haz_pkg.sv
// ----------------------------------------------------------------------------
// haz_pkg
// Shared types and defaults for the hazard detector slice.
//   haz_flags_t     : bundle of hazard flags handed to the resolver
//   shadow_entry_t  : one in-flight instruction slot (EX/MEM/WB shadow)
//   src_match()     : "does this source read what this entry will write"
// ----------------------------------------------------------------------------
package haz_pkg;

   localparam int REG_AW_DEF  = 5;
   localparam int MUL_LAT_DEF = 4;
   localparam int MAX_BR_DEF  = 2;

   // Destination field width in a shadow entry. Register addresses are
   // zero-extended into it, so any REG_AW up to this width is supported.
   localparam int SHADOW_RD_W = 8;

   typedef struct packed {
      logic data;
      logic fwrd;
      logic str;
      logic ctrl;
      logic branch;
      logic crct;
   } haz_flags_t;

   typedef struct packed {
      logic                   v;
      logic [SHADOW_RD_W-1:0] rd;
      logic                   we;
      logic                   load;
   } shadow_entry_t;

   localparam shadow_entry_t SHADOW_BUBBLE = '0;

   // Register 0 is hardwired zero, so it can never carry a dependency.
   function automatic logic src_match(input logic                   used,
                                      input logic [SHADOW_RD_W-1:0] src,
                                      input shadow_entry_t          e);
      return used & e.v & e.we & (e.rd == src) & (src != '0);
   endfunction

endpackage

// File: rtl/haz_shadow_pipe.sv
// ----------------------------------------------------------------------------
// haz_shadow_pipe
// Shadow copy of the EX/MEM/WB occupancy of the core. Every cycle the slots
// shift by one; EX takes the ID instruction only when it is accepted,
// otherwise a bubble. A flush kills what sits in EX and MEM.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   accept_i      : ID instruction enters EX this cycle
//   flush_i       : invalidate EX and MEM at this edge
//   id_entry_i    : shadow fields of the ID instruction
//   ex_o/mem_o/wb_o : current shadow slots
// ----------------------------------------------------------------------------
module haz_shadow_pipe
   import haz_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          accept_i,
   input  logic          flush_i,
   input  shadow_entry_t id_entry_i,
   output shadow_entry_t ex_o,
   output shadow_entry_t mem_o,
   output shadow_entry_t wb_o
);

   localparam int NSTG    = 3;
   localparam int STG_MEM = 1;

   shadow_entry_t stage_q [NSTG];
   shadow_entry_t stage_d [NSTG];

   // accept is already low during a flush, so EX needs no separate kill.
   assign stage_d[0] = accept_i ? id_entry_i : SHADOW_BUBBLE;

   genvar gi;
   for (gi = 1; gi < NSTG; gi++) begin : g_next
      if (gi == STG_MEM) begin : g_mem
         assign stage_d[gi] = flush_i ? SHADOW_BUBBLE : stage_q[gi-1];
      end else begin : g_plain
         assign stage_d[gi] = stage_q[gi-1];
      end
   end

   for (gi = 0; gi < NSTG; gi++) begin : g_reg
      always_ff @(posedge clk) begin
         if (rst) begin
            stage_q[gi] <= SHADOW_BUBBLE;
         end else begin
            stage_q[gi] <= stage_d[gi];
         end
      end
   end

   assign ex_o  = stage_q[0];
   assign mem_o = stage_q[1];
   assign wb_o  = stage_q[2];

endmodule

// File: rtl/haz_detector.sv
// ----------------------------------------------------------------------------
// haz_detector
// Producer of hazard flags for the resolver FSM. Watches the ID instruction,
// keeps a shadow of in-flight instructions, and tracks multiplier occupancy
// and outstanding branches.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   issue_valid                 : valid instruction in ID
//   rs1/rs2, rs1_used/rs2_used  : source registers and whether they are read
//   rd, rd_we                   : destination and write enable
//   is_load/is_mul/is_branch    : ID instruction class
//   br_res_valid                : EX resolves the oldest outstanding branch
//   br_taken, br_pred           : actual and predicted branch outcome
//   pc_freeze, do_flush         : resolver feedback used to steer the shadow
//   resolved                    : resolver feedback, only checked
//   data, fwrd, str, ctrl       : combinational hazard flags
//   branch, crct                : registered branch-resolution pulses
// ----------------------------------------------------------------------------
module haz_detector
   import haz_pkg::*;
#(
   parameter int REG_AW  = REG_AW_DEF,
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int MAX_BR  = MAX_BR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic              rs1_used,
   input  logic              rs2_used,
   input  logic [REG_AW-1:0] rd,
   input  logic              rd_we,
   input  logic              is_load,
   input  logic              is_mul,
   input  logic              is_branch,
   input  logic              br_res_valid,
   input  logic              br_taken,
   input  logic              br_pred,
   input  logic              pc_freeze,
   input  logic              do_flush,
   input  logic              resolved,
   output logic              data,
   output logic              fwrd,
   output logic              str,
   output logic              ctrl,
   output logic              branch,
   output logic              crct
);

   localparam int MUL_CW = $clog2(MUL_LAT);
   localparam int BR_CW  = $clog2(MAX_BR + 1);

   logic accept;
   assign accept = issue_valid & ~pc_freeze & ~do_flush;

   // ---------------- shadow pipeline ----------------
   shadow_entry_t id_entry, ex_entry, mem_entry, wb_entry;

   always_comb begin
      id_entry      = SHADOW_BUBBLE;
      id_entry.v    = 1'b1;
      id_entry.rd   = SHADOW_RD_W'(rd);
      id_entry.we   = rd_we;
      id_entry.load = is_load;
   end

   haz_shadow_pipe u_shadow (
      .clk        (clk),
      .rst        (rst),
      .accept_i   (accept),
      .flush_i    (do_flush),
      .id_entry_i (id_entry),
      .ex_o       (ex_entry),
      .mem_o      (mem_entry),
      .wb_o       (wb_entry)
   );

   // WB can no longer be forwarded from, so it never raises a flag.
   logic wb_unused;
   assign wb_unused = ^wb_entry;

   // ---------------- source matching ----------------
   logic [1:0]             src_used;
   logic [SHADOW_RD_W-1:0] src_addr [2];
   logic [1:0]             hit_ex;
   logic [1:0]             hit_mem;

   assign src_used    = {rs2_used, rs1_used};
   assign src_addr[0] = SHADOW_RD_W'(rs1);
   assign src_addr[1] = SHADOW_RD_W'(rs2);

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_src
      assign hit_ex[gi]  = src_match(src_used[gi], src_addr[gi], ex_entry);
      assign hit_mem[gi] = src_match(src_used[gi], src_addr[gi], mem_entry);
   end

   // ---------------- multiplier occupancy ----------------
   logic [MUL_CW-1:0] mul_cnt_q, mul_cnt_d;

   always_comb begin
      mul_cnt_d = mul_cnt_q;
      if (accept && is_mul) begin
         mul_cnt_d = MUL_CW'(MUL_LAT - 1);
      end else if (mul_cnt_q != '0) begin
         mul_cnt_d = mul_cnt_q - MUL_CW'(1);
      end
   end

   // ---------------- outstanding branches ----------------
   logic [BR_CW-1:0] br_cnt_q, br_cnt_d;
   logic             br_full, br_inc, br_dec;

   assign br_full = (br_cnt_q == BR_CW'(MAX_BR));
   assign br_inc  = accept & is_branch;
   // A resolution with nothing outstanding is stray and must not underflow.
   assign br_dec  = br_res_valid & (br_cnt_q != '0);

   always_comb begin
      br_cnt_d = br_cnt_q;
      if (do_flush) begin
         br_cnt_d = '0;
      end else if (br_inc && !br_dec && !br_full) begin
         br_cnt_d = br_cnt_q + BR_CW'(1);
      end else if (br_dec && !br_inc) begin
         br_cnt_d = br_cnt_q - BR_CW'(1);
      end
   end

   // ---------------- state registers ----------------
   logic branch_q, branch_d;
   logic crct_q, crct_d;

   assign branch_d = br_res_valid & (br_cnt_q != '0);
   assign crct_d   = br_res_valid & (br_taken == br_pred);

   always_ff @(posedge clk) begin
      if (rst) begin
         mul_cnt_q <= '0;
         br_cnt_q  <= '0;
         branch_q  <= 1'b0;
         crct_q    <= 1'b0;
      end else begin
         mul_cnt_q <= mul_cnt_d;
         br_cnt_q  <= br_cnt_d;
         branch_q  <= branch_d;
         crct_q    <= crct_d;
      end
   end

   // ---------------- flags ----------------
   haz_flags_t flags;

   always_comb begin
      flags        = '0;
      flags.data   = issue_valid & ((|hit_ex) | (|hit_mem));
      // A load still in EX has no data yet; a load in MEM can be forwarded.
      flags.fwrd   = flags.data & ~((|hit_ex) & ex_entry.load);
      flags.str    = issue_valid & ((is_mul & (mul_cnt_q != '0)) |
                                    (is_branch & br_full));
      flags.ctrl   = (br_cnt_q != '0);
      flags.branch = branch_q;
      flags.crct   = crct_q;
   end

   assign data   = flags.data;
   assign fwrd   = flags.fwrd;
   assign str    = flags.str;
   assign ctrl   = flags.ctrl;
   assign branch = flags.branch;
   assign crct   = flags.crct;

   // The resolver must never report completion while it is still freezing.
   a_resolved_not_frozen : assert property (
      @(posedge clk) disable iff (rst) !(resolved && pc_freeze));

endmodule

// File: tb/tb_haz_detector.sv
module tb_haz_detector;

   logic       clk;
   logic       rst;
   logic       issue_valid;
   logic [4:0] rs1, rs2, rd;
   logic       rs1_used, rs2_used, rd_we;
   logic       is_load, is_mul, is_branch;
   logic       br_res_valid, br_taken, br_pred;
   logic       pc_freeze, do_flush, resolved;
   logic       data, fwrd, str, ctrl, branch, crct;

   int n_cmp = 0;
   int n_bad = 0;

   haz_detector #(.REG_AW(5), .MUL_LAT(4), .MAX_BR(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .issue_valid  (issue_valid),
      .rs1          (rs1),
      .rs2          (rs2),
      .rs1_used     (rs1_used),
      .rs2_used     (rs2_used),
      .rd           (rd),
      .rd_we        (rd_we),
      .is_load      (is_load),
      .is_mul       (is_mul),
      .is_branch    (is_branch),
      .br_res_valid (br_res_valid),
      .br_taken     (br_taken),
      .br_pred      (br_pred),
      .pc_freeze    (pc_freeze),
      .do_flush     (do_flush),
      .resolved     (resolved),
      .data         (data),
      .fwrd         (fwrd),
      .str          (str),
      .ctrl         (ctrl),
      .branch       (branch),
      .crct         (crct)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 0; rs1 = 0; rs2 = 0; rd = 0;
      rs1_used = 0; rs2_used = 0; rd_we = 0;
      is_load = 0; is_mul = 0; is_branch = 0;
      br_res_valid = 0; br_taken = 0; br_pred = 0;
      pc_freeze = 0; do_flush = 0; resolved = 0;
   endtask

   task automatic drain();
      idle();
      repeat (5) tick();
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      tick();
      tick();
      #1;
      $display("txn reset: flags=%b%b%b%b%b%b", data, fwrd, str, ctrl, branch, crct);
      n_cmp++; if (data !== 1'b0)   begin n_bad++; $display("FAIL reset_data: got %b want 0", data); end
      n_cmp++; if (fwrd !== 1'b0)   begin n_bad++; $display("FAIL reset_fwrd: got %b want 0", fwrd); end
      n_cmp++; if (str !== 1'b0)    begin n_bad++; $display("FAIL reset_str: got %b want 0", str); end
      n_cmp++; if (ctrl !== 1'b0)   begin n_bad++; $display("FAIL reset_ctrl: got %b want 0", ctrl); end
      n_cmp++; if (branch !== 1'b0) begin n_bad++; $display("FAIL reset_branch: got %b want 0", branch); end
      n_cmp++; if (crct !== 1'b0)   begin n_bad++; $display("FAIL reset_crct: got %b want 0", crct); end
      rst = 0;
      tick();
   endtask

   task automatic test_alu_raw();
      idle();
      issue_valid = 1; rd = 5'd3; rd_we = 1;
      #1;
      n_cmp++; if (data !== 1'b0) begin n_bad++; $display("FAIL raw_first_data: got %b want 0", data); end
      tick();
      idle();
      issue_valid = 1; rs1 = 5'd3; rs1_used = 1;
      #1;
      $display("txn alu_raw: data=%b fwrd=%b", data, fwrd);
      n_cmp++; if (data !== 1'b1) begin n_bad++; $display("FAIL raw_data: got %b want 1", data); end
      n_cmp++; if (fwrd !== 1'b1) begin n_bad++; $display("FAIL raw_fwrd: got %b want 1", fwrd); end
      // unused source must not match
      rs1_used = 0;
      #1;
      n_cmp++; if (data !== 1'b0) begin n_bad++; $display("FAIL raw_unused_data: got %b want 0", data); end
      drain();
   endtask

   task automatic test_load_use();
      idle();
      issue_valid = 1; rd = 5'd5; rd_we = 1; is_load = 1;
      tick();
      idle();
      issue_valid = 1; rs2 = 5'd5; rs2_used = 1;
      #1;
      $display("txn load_use_ex: data=%b fwrd=%b", data, fwrd);
      n_cmp++; if (data !== 1'b1) begin n_bad++; $display("FAIL lu_ex_data: got %b want 1", data); end
      n_cmp++; if (fwrd !== 1'b0) begin n_bad++; $display("FAIL lu_ex_fwrd: got %b want 0", fwrd); end
      pc_freeze = 1;
      tick();
      pc_freeze = 0;
      #1;
      $display("txn load_use_mem: data=%b fwrd=%b", data, fwrd);
      n_cmp++; if (data !== 1'b1) begin n_bad++; $display("FAIL lu_mem_data: got %b want 1", data); end
      n_cmp++; if (fwrd !== 1'b1) begin n_bad++; $display("FAIL lu_mem_fwrd: got %b want 1", fwrd); end
      drain();
   endtask

   task automatic test_zero_reg();
      idle();
      issue_valid = 1; rd = 5'd0; rd_we = 1;
      tick();
      idle();
      issue_valid = 1; rs1 = 5'd0; rs1_used = 1;
      #1;
      $display("txn zero_reg: data=%b", data);
      n_cmp++; if (data !== 1'b0) begin n_bad++; $display("FAIL zero_data: got %b want 0", data); end
      drain();
   endtask

   task automatic test_mul();
      idle();
      issue_valid = 1; is_mul = 1;
      #1;
      n_cmp++; if (str !== 1'b0) begin n_bad++; $display("FAIL mul_first_str: got %b want 0", str); end
      tick();
      // resolver stalls the second multiply while the unit is busy
      pc_freeze = 1;
      for (int k = 1; k <= 3; k++) begin
         #1;
         $display("txn mul t+%0d: str=%b", k, str);
         n_cmp++; if (str !== 1'b1) begin n_bad++; $display("FAIL mul_busy_str t+%0d: got %b want 1", k, str); end
         tick();
      end
      pc_freeze = 0;
      #1;
      $display("txn mul t+4: str=%b", str);
      n_cmp++; if (str !== 1'b0) begin n_bad++; $display("FAIL mul_free_str: got %b want 0", str); end
      drain();
   endtask

   task automatic test_branch_resolve(input logic taken, input logic pred);
      idle();
      #1;
      n_cmp++; if (ctrl !== 1'b0) begin n_bad++; $display("FAIL br_pre_ctrl: got %b want 0", ctrl); end
      issue_valid = 1; is_branch = 1;
      tick();
      idle();
      #1;
      n_cmp++; if (ctrl !== 1'b1) begin n_bad++; $display("FAIL br_pend_ctrl: got %b want 1", ctrl); end
      tick();
      br_res_valid = 1; br_taken = taken; br_pred = pred;
      #1;
      n_cmp++; if (ctrl !== 1'b1)   begin n_bad++; $display("FAIL br_res_ctrl: got %b want 1", ctrl); end
      n_cmp++; if (branch !== 1'b0) begin n_bad++; $display("FAIL br_early_branch: got %b want 0", branch); end
      tick();
      idle();
      #1;
      $display("txn branch taken=%b pred=%b: branch=%b crct=%b ctrl=%b", taken, pred, branch, crct, ctrl);
      n_cmp++; if (branch !== 1'b1)        begin n_bad++; $display("FAIL br_branch: got %b want 1", branch); end
      n_cmp++; if (crct !== (taken == pred)) begin n_bad++; $display("FAIL br_crct: got %b want %b", crct, taken == pred); end
      n_cmp++; if (ctrl !== 1'b0)          begin n_bad++; $display("FAIL br_post_ctrl: got %b want 0", ctrl); end
      tick();
      n_cmp++; if (branch !== 1'b0) begin n_bad++; $display("FAIL br_pulse_branch: got %b want 0", branch); end
      n_cmp++; if (crct !== 1'b0)   begin n_bad++; $display("FAIL br_pulse_crct: got %b want 0", crct); end
      drain();
   endtask

   task automatic test_branch_limit_flush();
      idle();
      issue_valid = 1; is_branch = 1;
      tick();
      tick();
      idle();
      issue_valid = 1; rd = 5'd7; rd_we = 1;
      tick();
      idle();
      issue_valid = 1; is_branch = 1;
      #1;
      $display("txn branch_limit: str=%b ctrl=%b", str, ctrl);
      n_cmp++; if (str !== 1'b1)  begin n_bad++; $display("FAIL lim_str: got %b want 1", str); end
      n_cmp++; if (ctrl !== 1'b1) begin n_bad++; $display("FAIL lim_ctrl: got %b want 1", ctrl); end
      // flush and freeze together: flush wins
      do_flush = 1; pc_freeze = 1;
      tick();
      idle();
      issue_valid = 1; rs1 = 5'd7; rs1_used = 1;
      #1;
      $display("txn flush: data=%b ctrl=%b", data, ctrl);
      n_cmp++; if (ctrl !== 1'b0) begin n_bad++; $display("FAIL flush_ctrl: got %b want 0", ctrl); end
      n_cmp++; if (data !== 1'b0) begin n_bad++; $display("FAIL flush_data: got %b want 0", data); end
      drain();
   endtask

   task automatic test_mid_reset();
      idle();
      issue_valid = 1; is_branch = 1;
      tick();
      idle();
      rst = 1; br_res_valid = 1;
      tick();
      #1;
      $display("txn mid_reset: ctrl=%b branch=%b crct=%b", ctrl, branch, crct);
      n_cmp++; if (ctrl !== 1'b0)   begin n_bad++; $display("FAIL mrst_ctrl: got %b want 0", ctrl); end
      n_cmp++; if (branch !== 1'b0) begin n_bad++; $display("FAIL mrst_branch: got %b want 0", branch); end
      n_cmp++; if (crct !== 1'b0)   begin n_bad++; $display("FAIL mrst_crct: got %b want 0", crct); end
      rst = 0;
      // stray resolution with nothing outstanding: no branch pulse, no underflow
      br_res_valid = 1; br_taken = 1; br_pred = 1;
      tick();
      idle();
      #1;
      $display("txn stray_resolve: branch=%b crct=%b ctrl=%b", branch, crct, ctrl);
      n_cmp++; if (branch !== 1'b0) begin n_bad++; $display("FAIL stray_branch: got %b want 0", branch); end
      n_cmp++; if (crct !== 1'b1)   begin n_bad++; $display("FAIL stray_crct: got %b want 1", crct); end
      n_cmp++; if (ctrl !== 1'b0)   begin n_bad++; $display("FAIL stray_ctrl: got %b want 0", ctrl); end
      drain();
   endtask

   initial begin
      rst = 1;
      idle();
      test_reset();
      test_alu_raw();
      test_load_use();
      test_zero_reg();
      test_mul();
      test_branch_resolve(1'b1, 1'b0);
      test_branch_resolve(1'b1, 1'b1);
      test_branch_limit_flush();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
